piso: RTL and testbench

//   Parallel-in serial-out shifter; the transmit-side counterpart of SIPO.

---
 rtl/piso.sv | 55 +++++
 tb/tb_piso.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/piso.sv
// piso: parallel-in serial-out shifter with valid/ready load and per-symbol enable
module piso #(
  parameter int SIZE_DATA_IN  = 8,
  parameter int SIZE_DATA_OUT = 1,
  parameter int MSB_FIRST     = 1
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_valid,
  input  logic [SIZE_DATA_IN-1:0]  i_data,
  output logic                     o_ready,
  input  logic                     i_en,
  output logic [SIZE_DATA_OUT-1:0] o_data,
  output logic                     o_valid,
  output logic                     o_last,
  output logic                     o_done
);
  localparam int NUM_SHIFT = SIZE_DATA_IN / SIZE_DATA_OUT;
  localparam int CNT_W = NUM_SHIFT > 1 ? $clog2(NUM_SHIFT) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(NUM_SHIFT - 1);
  typedef enum logic {IDLE, SHIFT} state_t;
  state_t state, state_nxt;
  logic [NUM_SHIFT-1:0][SIZE_DATA_OUT-1:0] word;
  logic [CNT_W-1:0] cnt, idx;
  logic shift, last, consume, accept;
  always_comb begin
    shift = state == SHIFT;
    last = shift && cnt == LAST;
    consume = last && i_en;
    o_ready = !shift || consume;
    accept = i_valid && o_ready;
    idx = MSB_FIRST != 0 ? LAST - cnt : cnt;
    o_valid = shift;
    o_last = last;
    o_data = shift ? word[idx] : '0;
    state_nxt = accept ? SHIFT : consume ? IDLE : state;
  end
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) state <= IDLE;
    else state <= state_nxt;
  // the counter reloads to 0 on accept or word end, so it never passes LAST
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      word <= '0;
      cnt <= '0;
      o_done <= 1'b0;
    end else begin
      o_done <= consume;
      if (accept) begin
        word <= i_data;
        cnt <= '0;
      end else if (consume) cnt <= '0;
      else if (shift && i_en) cnt <= cnt + CNT_W'(1);
    end
endmodule

// File: tb/tb_piso.sv
// tb_piso: randomized and directed checks of piso against a word/position model
module tb_piso;
  logic clk = 0;
  logic rst_n = 0;
  logic i_valid = 0;
  logic [7:0] i_data = 0;
  logic i_en = 0;
  logic ready_m, valid_m, last_m, done_m, ready_l, valid_l, last_l, done_l;
  logic [0:0] data_m, data_l;
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  piso #(.SIZE_DATA_IN(8), .SIZE_DATA_OUT(1), .MSB_FIRST(1)) u_msb (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(i_valid), .i_data(i_data), .o_ready(ready_m),
    .i_en(i_en), .o_data(data_m), .o_valid(valid_m), .o_last(last_m), .o_done(done_m));
  piso #(.SIZE_DATA_IN(8), .SIZE_DATA_OUT(1), .MSB_FIRST(0)) u_lsb (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(i_valid), .i_data(i_data), .o_ready(ready_l),
    .i_en(i_en), .o_data(data_l), .o_valid(valid_l), .o_last(last_l), .o_done(done_l));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic sym(input logic [7:0] w, input int k, input bit msb);
    return msb ? w[7-k] : w[k];
  endfunction

  // model: the word being sent and which symbol position is on the output (-1 = idle)
  int pos = -1;
  logic [7:0] cur = 0;
  logic done_e = 0;
  logic [7:0] q_m[$], q_l[$];
  logic [7:0] acc_m = 0, acc_l = 0;
  logic last_e, acc_e;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pos = -1;
      done_e = 0;
      acc_m = 0;
      acc_l = 0;
      q_m.delete();
      q_l.delete();
    end else begin
      if (valid_m && i_en) begin
        acc_m = {acc_m[6:0], data_m};
        if (last_m) chk("sipo_msb", acc_m, q_m.size() != 0 ? q_m.pop_front() : ~acc_m);
      end
      if (valid_l && i_en) begin
        acc_l = {data_l, acc_l[7:1]};
        if (last_l) chk("sipo_lsb", acc_l, q_l.size() != 0 ? q_l.pop_front() : ~acc_l);
      end
      last_e = pos == 7;
      acc_e = i_valid && (pos < 0 || (last_e && i_en));
      done_e = last_e && i_en;
      if (acc_e) begin
        cur = i_data;
        pos = 0;
        q_m.push_back(i_data);
        q_l.push_back(i_data);
      end else if (pos >= 0 && i_en) pos = last_e ? -1 : pos + 1;
    end
  end

  always @(posedge clk) begin
    #2;
    chk("msb_valid", valid_m, pos >= 0);
    chk("msb_last", last_m, pos == 7);
    chk("msb_data", data_m, pos >= 0 ? sym(cur, pos, 1) : 1'b0);
    chk("msb_done", done_m, done_e);
    chk("msb_ready", ready_m, pos < 0 || (pos == 7 && i_en));
    chk("lsb_valid", valid_l, pos >= 0);
    chk("lsb_last", last_l, pos == 7);
    chk("lsb_data", data_l, pos >= 0 ? sym(cur, pos, 0) : 1'b0);
    chk("lsb_done", done_l, done_e);
    chk("lsb_ready", ready_l, pos < 0 || (pos == 7 && i_en));
  end

  task automatic chk_reset(input string name);
    chk({name, "_out"}, {data_m, valid_m, last_m, done_m, data_l, valid_l, last_l, done_l}, 0);
    chk({name, "_ready"}, {ready_m, ready_l}, 2'b11);
  endtask

  task automatic send(input logic [7:0] w, input int psym, input int plen,
                      output logic [7:0] ms, output logic [7:0] ls, output int dc);
    int n, p;
    n = 0; p = 0; ms = 0; ls = 0; dc = 0;
    i_valid = 1; i_data = w; i_en = 1;
    for (int c = 1; c <= 16; c++) begin
      @(negedge clk);
      if (c == 1) i_valid = 0;
      i_en = !(n == psym && p < plen);
      if (!i_en) p++;
      #1;
      if (!i_en) chk("pause_hold", {valid_m, data_m}, {1'b1, sym(w, psym, 1)});
      if (valid_m && i_en) begin
        ms = {ms[6:0], data_m};
        ls = {ls[6:0], data_l};
        n++;
      end
      if (done_m) dc = c;
    end
    chk("ready_after_word", ready_m, 1);
  endtask

  task automatic stream2(input logic [7:0] w0, input logic [7:0] w1, input int raise,
                         output logic [15:0] s, output int dc);
    s = 0; dc = 0;
    i_valid = 1; i_data = w0; i_en = 1;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (c == raise) begin
        i_valid = 1;
        i_data = w1;
        #1 chk("busy_ready", ready_m, 0);
      end else if (c < raise) i_valid = 0;
      if (c == 9) i_valid = 0;
      #1;
      if (c == 9) chk("b2b_sym0_valid", valid_m, 1);
      if (valid_m) s = {s[14:0], data_m};
      if (done_m && dc == 0) dc = c;
    end
  endtask

  logic [7:0] ms, ls;
  logic [15:0] s16;
  int dc;
  logic [7:0] msb_seq[8] = '{1, 0, 1, 1, 0, 1, 0, 0};
  logic [7:0] lsb_seq[8] = '{0, 0, 1, 0, 1, 1, 0, 1};

  initial begin
    #1 chk_reset("rst_t0");
    for (int k = 0; k < 8; k++) begin
      chk("model_msb_sym", sym(8'hB4, k, 1), msb_seq[k]);
      chk("model_lsb_sym", sym(8'hB4, k, 0), lsb_seq[k]);
    end
    repeat (2) @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    send(8'hB4, -1, 0, ms, ls, dc);
    chk("t2_stream", ms, 8'hB4);
    chk("t2_lsb_stream", ls, 8'h2D);
    chk("t2_done_cycle", dc, 9);
    send(8'hB4, 3, 3, ms, ls, dc);
    chk("t3_stream", ms, 8'hB4);
    chk("t3_done_cycle", dc, 12);
    stream2(8'hB4, 8'h5A, 1, s16, dc);
    chk("t4_stream", s16, 16'hB45A);
    chk("t4_done_cycle", dc, 9);
    stream2(8'h0F, 8'hFF, 3, s16, dc);
    chk("t5_stream", s16, 16'h0FFF);
    chk("t5_done_cycle", dc, 9);
    i_valid = 1; i_data = 8'hB4; i_en = 1;
    @(negedge clk);
    i_valid = 0;
    repeat (4) @(negedge clk);
    #3 rst_n = 0;
    #1 chk_reset("t6_async");
    @(negedge clk);
    rst_n = 1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      #1 chk("t6_no_done", {done_m, valid_m}, 0);
    end
    send(8'hFF, -1, 0, ms, ls, dc);
    chk("t6_stream", ms, 8'hFF);
    chk("t6_done_cycle", dc, 9);
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      i_valid = $urandom_range(0, 2) != 0;
      i_data = 8'($urandom);
      i_en = $urandom_range(0, 3) != 0;
      if ($urandom_range(0, 299) == 0) begin
        #3 rst_n = 0;
        #1 chk_reset("rand_async");
        @(negedge clk);
        rst_n = 1;
      end
    end
    @(negedge clk);
    i_valid = 0;
    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
